// File: rtl/cdu_pkg.sv
// cdu_pkg: shared types and default constants for the CDU read-counter slice.
package cdu_pkg;

  // Step rate selected from the error-angle threshold levels
  typedef enum logic [1:0] {
    RATE_NONE = 2'd0,
    RATE_HI   = 2'd1,
    RATE_LO   = 2'd2
  } rate_e;

  // AGC pulse generator states
  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_PULSE = 2'd1,
    PG_GAP   = 2'd2
  } pg_state_e;

  // 12.8 kpps and 800 pps at a 1.024 MHz CLOCKH
  localparam int unsigned HI_DIV_DEF    = 80;
  localparam int unsigned LO_DIV_DEF    = 1280;
  localparam int unsigned PULSE_W_DEF   = 8;
  localparam int unsigned PULSE_GAP_DEF = 8;
  localparam int unsigned QUEUE_MAX_DEF = 7;

endpackage

// File: rtl/agc_pulse_gen.sv
// agc_pulse_gen: pending-pulse queue and PCDU/MCDU pulse FSM.
// Build macro CDU_PULSE_QUEUE_EN: defined gives a signed pending count
// saturating at +/-QUEUE_MAX; undefined gives a single pending pulse, and
// any bit-1 event that cannot be held is dropped and flagged in qovf.
module agc_pulse_gen
  import cdu_pkg::*;
#(
  parameter int unsigned PULSE_W   = PULSE_W_DEF,
  parameter int unsigned PULSE_GAP = PULSE_GAP_DEF,
  parameter int unsigned QUEUE_MAX = QUEUE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic zero,
  input  logic inc,
  input  logic dec,
  output logic pcdu,
  output logic mcdu,
  output logic qovf
);

  localparam int unsigned Q_W   = $clog2(QUEUE_MAX + 1) + 1;
  localparam int unsigned T_MAX = (PULSE_W > PULSE_GAP) ? PULSE_W : PULSE_GAP;
  localparam int unsigned T_W   = $clog2(T_MAX + 1);

  pg_state_e             state_q, state_d;
  logic [T_W-1:0]        tmr_q, tmr_d;
  logic                  sign_q, sign_d;
  logic signed [Q_W-1:0] q_q, q_d;
  logic                  ovf_q, ovf_d;
  logic                  launch;

  // A new pulse only leaves IDLE with something pending and no zeroing in force
  assign launch = (state_q == PG_IDLE) && (q_q != '0) && !zero;

`ifdef CDU_PULSE_QUEUE_EN
  localparam logic signed [Q_W:0] QMAX_S = (Q_W+1)'(QUEUE_MAX);
  localparam logic signed [Q_W:0] QMIN_S = -QMAX_S;
  localparam logic signed [Q_W:0] ONE_S  = (Q_W+1)'(1);

  function automatic logic signed [Q_W-1:0] q_sat(input logic signed [Q_W:0] s);
    if (s > QMAX_S)      return QMAX_S[Q_W-1:0];
    else if (s < QMIN_S) return QMIN_S[Q_W-1:0];
    else                 return s[Q_W-1:0];
  endfunction

  function automatic logic q_hit(input logic signed [Q_W:0] s);
    return (s > QMAX_S) || (s < QMIN_S);
  endfunction

  logic signed [Q_W:0] q_sum;

  // Launch moves the count toward zero, bit-1 events add +/-1, saturation applied after both
  always_comb begin
    q_sum = {q_q[Q_W-1], q_q};
    if (launch) q_sum = q_q[Q_W-1] ? q_sum + ONE_S : q_sum - ONE_S;
    if (inc)      q_sum = q_sum + ONE_S;
    else if (dec) q_sum = q_sum - ONE_S;
    q_d   = q_sat(q_sum);
    ovf_d = ovf_q | q_hit(q_sum);
    if (zero) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end
  end
`else
  localparam logic signed [Q_W-1:0] ONE_Q = Q_W'(1);

  // Single pending pulse: an event arriving while one is pending or in flight is dropped,
  // except an opposite event which cancels a pulse that has not launched yet
  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (launch) q_d = '0;
    if (inc || dec) begin
      if (launch || (state_q != PG_IDLE)) ovf_d = 1'b1;
      else if (q_q == '0)                 q_d   = inc ? ONE_Q : -ONE_Q;
      else if (inc == q_q[Q_W-1])         q_d   = '0;
      else                                ovf_d = 1'b1;
    end
    if (zero) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end
  end
`endif

  // Pulse FSM next state: PULSE_W cycles high, then at least PULSE_GAP cycles low
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sign_d  = sign_q;
    case (state_q)
      PG_IDLE: begin
        if (launch) begin
          state_d = PG_PULSE;
          tmr_d   = '0;
          sign_d  = ~q_q[Q_W-1];
        end
      end
      PG_PULSE: begin
        if (tmr_q == T_W'(PULSE_W - 1)) begin
          state_d = PG_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      PG_GAP: begin
        if (tmr_q == T_W'(PULSE_GAP - 1)) begin
          state_d = PG_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = PG_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // State, queue and overflow registers; reset kills a pulse in progress immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PG_IDLE;
      tmr_q   <= '0;
      sign_q  <= 1'b0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sign_q  <= sign_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pcdu = (state_q == PG_PULSE) &  sign_q;
  assign mcdu = (state_q == PG_PULSE) & ~sign_q;
  assign qovf = ovf_q;

endmodule

// File: rtl/read_counter.sv
// read_counter: CDU read counter. Steps a 16-bit angle count toward null at
// the rate chosen by the threshold levels and turns every change of count
// bit 1 into a spaced PCDU/MCDU pulse for the AGC.
// Build macro CDU_PULSE_QUEUE_EN enables the multi-entry pulse queue.
module read_counter
  import cdu_pkg::*;
#(
  parameter int unsigned HI_DIV    = HI_DIV_DEF,
  parameter int unsigned LO_DIV    = LO_DIV_DEF,
  parameter int unsigned PULSE_W   = PULSE_W_DEF,
  parameter int unsigned PULSE_GAP = PULSE_GAP_DEF,
  parameter int unsigned QUEUE_MAX = QUEUE_MAX_DEF
) (
  input  logic        CLOCKH,
  input  logic        rst_n,
  input  logic        _UPLVL,
  input  logic        _DNLVL,
  input  logic        _TPC1,
  input  logic        _TPF1,
  input  logic        _TPF2,
  input  logic        _ZERO,
  output logic [15:0] _CNT,
  output logic        _PCDU,
  output logic        _MCDU,
  output logic        _QOVF
);

  localparam int unsigned DIV_MAX = (HI_DIV > LO_DIV) ? HI_DIV : LO_DIV;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);

  rate_e            rate_sel, rate_q;
  logic [DIV_W-1:0] div_q, div_last;
  logic             strobe;
  logic             dir_up, dir_dn;
  logic             step_up, step_dn;
  logic             b1_inc, b1_dec;

  // Rate, direction and step decode; a step is inhibited while zeroing
  always_comb begin
    rate_sel = RATE_NONE;
    if (_TPC1 || _TPF1) rate_sel = RATE_HI;
    else if (_TPF2)     rate_sel = RATE_LO;
    dir_up   = _UPLVL & ~_DNLVL;
    dir_dn   = _DNLVL & ~_UPLVL;
    div_last = (rate_sel == RATE_HI) ? DIV_W'(HI_DIV - 1) : DIV_W'(LO_DIV - 1);
    strobe   = (rate_sel == rate_q) && (rate_sel != RATE_NONE) &&
               (div_q == div_last) && !_ZERO;
    step_up  = strobe & dir_up;
    step_dn  = strobe & dir_dn;
    // Count bit 1 flips on an up step from an odd count, or a down step from an even count
    b1_inc   = step_up &  _CNT[0];
    b1_dec   = step_dn & ~_CNT[0];
  end

  // Rate divider restarts whenever the rate changes, is NONE, or zeroing is active
  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      rate_q <= RATE_NONE;
      div_q  <= '0;
    end else begin
      rate_q <= rate_sel;
      if (_ZERO || (rate_sel != rate_q) || (rate_sel == RATE_NONE) || strobe)
        div_q <= '0;
      else
        div_q <= div_q + 1'b1;
    end
  end

  // Angle counter, wraps freely in both directions
  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n)       _CNT <= '0;
    else if (_ZERO)   _CNT <= '0;
    else if (step_up) _CNT <= _CNT + 16'd1;
    else if (step_dn) _CNT <= _CNT - 16'd1;
  end

  agc_pulse_gen #(
    .PULSE_W   (PULSE_W),
    .PULSE_GAP (PULSE_GAP),
    .QUEUE_MAX (QUEUE_MAX)
  ) u_agc (
    .clk   (CLOCKH),
    .rst_n (rst_n),
    .zero  (_ZERO),
    .inc   (b1_inc),
    .dec   (b1_dec),
    .pcdu  (_PCDU),
    .mcdu  (_MCDU),
    .qovf  (_QOVF)
  );

endmodule

// File: tb/tb_read_counter.sv
// tb_read_counter: directed bench for read_counter with default dividers
// (dut1) and a fast high-rate divider (dut2) sharing the same stimulus.
module tb_read_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uplvl = 1'b0, dnlvl = 1'b0;
  logic        tpc1 = 1'b0, tpf1 = 1'b0, tpf2 = 1'b0, zero = 1'b0;
  logic [15:0] cnt1, cnt2;
  logic        pcdu1, mcdu1, qovf1;
  logic        pcdu2, mcdu2, qovf2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  read_counter dut1 (
    .CLOCKH(clk), .rst_n(rst_n), ._UPLVL(uplvl), ._DNLVL(dnlvl),
    ._TPC1(tpc1), ._TPF1(tpf1), ._TPF2(tpf2), ._ZERO(zero),
    ._CNT(cnt1), ._PCDU(pcdu1), ._MCDU(mcdu1), ._QOVF(qovf1)
  );

  read_counter #(.HI_DIV(2)) dut2 (
    .CLOCKH(clk), .rst_n(rst_n), ._UPLVL(uplvl), ._DNLVL(dnlvl),
    ._TPC1(tpc1), ._TPF1(tpf1), ._TPF2(tpf2), ._ZERO(zero),
    ._CNT(cnt2), ._PCDU(pcdu2), ._MCDU(mcdu2), ._QOVF(qovf2)
  );

  // Pulse monitors, sampled on the falling edge
  int   p_rise = 0, p_hi = 0, m_rise = 0, m_hi = 0;
  int   m_low = 0, m_last_gap = 0, both_hi = 0;
  int   p2_rise = 0, p2_run = 0, p2_last_w = 0;
  logic p1_prev = 1'b0, m1_prev = 1'b0, p2_prev = 1'b0;

  always @(negedge clk) begin
    if (pcdu1 && !p1_prev) p_rise <= p_rise + 1;
    if (pcdu1) p_hi <= p_hi + 1;
    if (mcdu1 && !m1_prev) begin
      m_rise     <= m_rise + 1;
      m_last_gap <= m_low;
    end
    if (mcdu1) begin
      m_hi  <= m_hi + 1;
      m_low <= 0;
    end else begin
      m_low <= m_low + 1;
    end
    if ((pcdu1 && mcdu1) || (pcdu2 && mcdu2)) both_hi <= both_hi + 1;
    if (pcdu2 && !p2_prev) p2_rise <= p2_rise + 1;
    if (pcdu2) p2_run <= p2_run + 1;
    else begin
      if (p2_prev) p2_last_w <= p2_run;
      p2_run <= 0;
    end
    p1_prev <= pcdu1;
    m1_prev <= mcdu1;
    p2_prev <= pcdu2;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    uplvl = 1'b0; dnlvl = 1'b0;
    tpc1 = 1'b0; tpf1 = 1'b0; tpf2 = 1'b0; zero = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  // Wait (bounded) until dut2 starts a fresh PCDU pulse
  task automatic wait_p2_rise(output bit ok);
    int k;
    ok = 1'b0;
    k = 0;
    while (pcdu2 && k < 60) begin tick(1); k++; end
    k = 0;
    while (!pcdu2 && k < 60) begin tick(1); k++; end
    ok = pcdu2;
  endtask

  int p_b, m_b, ph_b, mh_b, p2_b;
  bit ok;

  initial begin
    do_reset();
    check_val("rst_cnt",  cnt1,  0);
    check_val("rst_pcdu", pcdu1, 0);
    check_val("rst_mcdu", mcdu1, 0);
    check_val("rst_qovf", qovf1, 0);

    // Low rate up: steps at 1280 and 2560, one PCDU pulse after the second
    p_b = p_rise; ph_b = p_hi;
    tpf2 = 1'b1; uplvl = 1'b1;
    tick(1);
    tick(1279); check_val("t1_cnt_1279", cnt1, 0);
    tick(1);    check_val("t1_cnt_1280", cnt1, 1);
    tick(1279); check_val("t1_cnt_2559", cnt1, 1);
    tick(1);    check_val("t1_cnt_2560", cnt1, 2);
    tpf2 = 1'b0; uplvl = 1'b0;
    tick(40);
    check_val("t1_pcdu_pulses", p_rise - p_b, 1);
    check_val("t1_pcdu_width",  p_hi - ph_b,  8);

    // High rate down from zero: wraps to 0xFFFC, two MCDU pulses
    do_reset();
    m_b = m_rise; mh_b = m_hi;
    tpc1 = 1'b1; dnlvl = 1'b1;
    tick(1);
    tick(320);
    check_val("t2_cnt", cnt1, 16'hFFFC);
    tpc1 = 1'b0; dnlvl = 1'b0;
    tick(40);
    check_val("t2_mcdu_pulses", m_rise - m_b, 2);
    check_val("t2_mcdu_hi",     m_hi - mh_b,  16);
    check_val("t2_gap_between", 32'(m_last_gap >= 8), 1);
    check_val("t2_gap_after",   32'(m_low >= 8), 1);

    // Conflicting direction: no motion, no pulses
    p_b = p_rise; m_b = m_rise;
    uplvl = 1'b1; dnlvl = 1'b1; tpf1 = 1'b1;
    tick(1000);
    check_val("t3_cnt",    cnt1, 16'hFFFC);
    check_val("t3_pulses", (p_rise - p_b) + (m_rise - m_b), 0);
    uplvl = 1'b0; dnlvl = 1'b0; tpf1 = 1'b0;

    // Fast divider overruns pulse capacity
    do_reset();
    tpc1 = 1'b1; uplvl = 1'b1;
    tick(1);
    tick(200);
    uplvl = 1'b0;
    p2_b = p2_rise;
    check_val("t4_dut1_cnt", cnt1, 2);
    tick(400);
    check_val("t4_qovf",      qovf2, 1);
    check_val("t4_dut1_qovf", qovf1, 0);
`ifdef CDU_PULSE_QUEUE_EN
    check_val("t4_drain_pulses", p2_rise - p2_b, 7);
`else
    check_val("t4_drain_le1", 32'((p2_rise - p2_b) <= 1), 1);
`endif
    tpc1 = 1'b0;

    // Zero mid-pulse: pulse completes, state cleared, nothing further
    do_reset();
    tpc1 = 1'b1; uplvl = 1'b1;
    tick(100);
    wait_p2_rise(ok);
    check_val("t5_rise_seen", ok, 1);
    tick(3);
    zero = 1'b1;
    tick(1);
    p2_b = p2_rise;
    check_val("t5_cnt",       cnt2,  0);
    check_val("t5_qovf",      qovf2, 0);
    check_val("t5_pulse_on",  pcdu2, 1);
    tick(60);
    check_val("t5_no_more",   p2_rise - p2_b, 0);
    check_val("t5_pulse_w",   p2_last_w, 8);
    zero = 1'b0; tpc1 = 1'b0; uplvl = 1'b0;

    // Asynchronous reset mid-pulse
    do_reset();
    tpc1 = 1'b1; uplvl = 1'b1;
    tick(100);
    wait_p2_rise(ok);
    check_val("t6_rise_seen", ok, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_pcdu", pcdu2, 0);
    check_val("t6_mcdu", mcdu2, 0);
    check_val("t6_cnt",  cnt2,  0);
    check_val("t6_qovf", qovf2, 0);
    tick(2);
    rst_n = 1'b1;
    tpc1 = 1'b0; uplvl = 1'b0;
    tick(2);

    check_val("both_pulses_high", both_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
